// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI mode-0 responder emulating the 25Q32 status-register path (WREN/WRDI/WRSR/RDSR).
// Optional macro SPI_RESP_SR2_EN enables RDSR2 (35h) and SR2 writes through a 2-byte WRSR.
module spi_flash_resp #(
  parameter int unsigned BUSY_CYCLES = 64,
  parameter logic [7:0]  SR1_RESET   = 8'h00,
  parameter logic [7:0]  SR2_RESET   = 8'h00
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       CS,
  input  logic       CLOCK,
  input  logic       IO0,
  inout  wire        IO1,
  inout  wire        IO2,
  inout  wire        IO3,
  output logic [7:0] status_reg1,
  output logic [7:0] status_reg2,
  output logic       busy,
  output logic       cmd_err
);
  localparam int unsigned CNT_W    = $clog2(BUSY_CYCLES + 1);
  localparam logic [7:0]  OP_WRSR  = 8'h01;
  localparam logic [7:0]  OP_WRDI  = 8'h04;
  localparam logic [7:0]  OP_RDSR1 = 8'h05;
  localparam logic [7:0]  OP_WREN  = 8'h06;
`ifdef SPI_RESP_SR2_EN
  localparam logic [7:0]  OP_RDSR2 = 8'h35;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT_CS, S_WRSR_DATA, S_READ_OUT, S_IGNORE
  } state_t;

  state_t           state, state_n;
  logic             cs_q, cs_q2, sck_q, sck_q2, io0_q;
  logic [2:0]       bit_cnt;
  logic [6:0]       shreg;
  logic [7:0]       out_sr;
  logic             io1_d, io1_oe;
  logic             pend_set;
  logic [1:0]       wr_cnt;
  logic [7:2]       d1_hi;
  logic [CNT_W-1:0] busy_cnt;
  logic [7:0]       sr1, sr2;
`ifdef SPI_RESP_SR2_EN
  logic [7:0]       d2;
  logic             rd_sr2;
`endif

  logic       rise_c, fall_c, cs_rise_c, cs_fall_c, byte_done_c;
  logic [7:0] byte_c;
  logic       err_c, commit_c, load_c;
  logic [7:0] load_val_c;

  assign rise_c      = sck_q & ~sck_q2;
  assign fall_c      = ~sck_q & sck_q2;
  assign cs_rise_c   = cs_q & ~cs_q2;
  assign cs_fall_c   = ~cs_q & cs_q2;
  assign byte_done_c = rise_c && !cs_q && (state != S_IDLE) && (bit_cnt == 3'd7);
  assign byte_c      = {shreg, io0_q};

  assign status_reg1 = sr1;
  assign status_reg2 = sr2;
  assign busy        = sr1[0];
  assign IO1         = io1_oe ? io1_d : 1'bz;
  assign IO2         = 1'bz;
  assign IO3         = 1'bz;

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_n;
  end

  // Opcode decode, CS-rise close-out and read-out reload control
  always_comb begin
    state_n    = state;
    err_c      = 1'b0;
    commit_c   = 1'b0;
    load_c     = 1'b0;
    load_val_c = sr1;
`ifdef SPI_RESP_SR2_EN
    if (rd_sr2) load_val_c = sr2;
`endif
    if (state != S_IDLE && cs_q) begin
      state_n = S_IDLE;
      if (cs_rise_c) begin
        if (bit_cnt != 3'd0 || (state == S_WRSR_DATA && wr_cnt == 2'd0)) err_c = 1'b1;
        else commit_c = 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: if (cs_fall_c) state_n = S_CMD;
        S_CMD: begin
          if (byte_done_c) begin
            case (byte_c)
              OP_WREN, OP_WRDI: begin
                if (sr1[0]) begin
                  state_n = S_IGNORE;
                  err_c   = 1'b1;
                end else begin
                  state_n = S_WAIT_CS;
                end
              end
              OP_WRSR: begin
                if (sr1[1] && !sr1[0]) begin
                  state_n = S_WRSR_DATA;
                end else begin
                  state_n = S_IGNORE;
                  err_c   = 1'b1;
                end
              end
              OP_RDSR1: begin
                state_n    = S_READ_OUT;
                load_c     = 1'b1;
                load_val_c = sr1;
              end
`ifdef SPI_RESP_SR2_EN
              OP_RDSR2: begin
                state_n    = S_READ_OUT;
                load_c     = 1'b1;
                load_val_c = sr2;
              end
`endif
              default: begin
                state_n = S_IGNORE;
                err_c   = 1'b1;
              end
            endcase
          end
        end
        S_WRSR_DATA: begin
          if (byte_done_c && wr_cnt == 2'd2) begin
            state_n = S_IGNORE;
            err_c   = 1'b1;
          end
        end
        S_READ_OUT: if (byte_done_c) load_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Pin synchronisers, shifters, transaction capture and status registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cs_q     <= 1'b0;
      cs_q2    <= 1'b0;
      sck_q    <= 1'b0;
      sck_q2   <= 1'b0;
      io0_q    <= 1'b0;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      out_sr   <= 8'd0;
      io1_d    <= 1'b0;
      io1_oe   <= 1'b0;
      pend_set <= 1'b0;
      wr_cnt   <= 2'd0;
      d1_hi    <= 6'd0;
      busy_cnt <= '0;
      sr1      <= SR1_RESET & 8'hFC;
      sr2      <= SR2_RESET;
      cmd_err  <= 1'b0;
`ifdef SPI_RESP_SR2_EN
      d2       <= 8'd0;
      rd_sr2   <= 1'b0;
`endif
    end else begin
      cs_q    <= CS;
      cs_q2   <= cs_q;
      sck_q   <= CLOCK;
      sck_q2  <= sck_q;
      io0_q   <= IO0;
      cmd_err <= err_c;
      io1_oe  <= (state_n == S_READ_OUT);

      // Bit counter only runs inside a framed command
      if (state == S_IDLE || cs_q) begin
        bit_cnt <= 3'd0;
      end else if (rise_c) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {shreg[5:0], io0_q};
      end

      if (state == S_CMD && byte_done_c) begin
        pend_set <= (byte_c == OP_WREN);
        wr_cnt   <= 2'd0;
`ifdef SPI_RESP_SR2_EN
        rd_sr2   <= (byte_c == OP_RDSR2);
`endif
      end

      if (state == S_WRSR_DATA && byte_done_c) begin
        if (wr_cnt == 2'd0) d1_hi <= byte_c[7:2];
`ifdef SPI_RESP_SR2_EN
        if (wr_cnt == 2'd1) d2 <= byte_c;
`endif
        if (wr_cnt != 2'd2) wr_cnt <= wr_cnt + 2'd1;
      end

      if (load_c) begin
        out_sr <= load_val_c;
      end else if (state == S_READ_OUT && fall_c) begin
        io1_d  <= out_sr[7];
        out_sr <= {out_sr[6:0], 1'b0};
      end

      // BUSY end clears WEL together with BUSY
      if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - CNT_W'(1);
        if (busy_cnt == CNT_W'(1)) sr1[1:0] <= 2'b00;
      end else if (commit_c) begin
        case (state)
          S_WAIT_CS: sr1[1] <= pend_set;
          S_WRSR_DATA: begin
            sr1[7:2] <= d1_hi;
            sr1[1:0] <= 2'b11;
            busy_cnt <= CNT_W'(BUSY_CYCLES);
`ifdef SPI_RESP_SR2_EN
            if (wr_cnt == 2'd2) sr2 <= d2;
`endif
          end
          default: ;
        endcase
      end
    end
  end
endmodule
